uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART byte receiver (uart_receive). It captures each byte the receiver flags and stores it in an internal FIWO-free first-word-fall-through FIFO. It completes the receiver's rx_finish handshake so the receiver returns to line-watching. It also presents bytes to the CPU/Wishbone register block through a valid/ready pop port, keeps overrun and frame-error status, and raises a level interrupt.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 66 ++++++
 rtl/uart_rx_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// FSM encodings and default sizes.
package uart_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Count is tracked separately from the wrapping pointers.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;
  logic             do_push;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  // A pop in the same cycle frees the slot of a full FIFO.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: capture, FIFO, status, irq.
// Completes the receiver's rx_finish handshake.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 rx_irq,
  input  logic [BYTE_W-1:0]    rx_data,
  input  logic                 rx_frame_err,
  output logic                 rx_finish,
  output logic                 rd_valid,
  output logic [BYTE_W-1:0]    rd_data,
  input  logic                 rd_ready,
  output logic [CNT_W-1:0]     fifo_count,
  input  logic [CNT_W-1:0]     irq_thresh,
  input  logic                 irq_en,
  input  logic                 clr_status,
  output logic                 status_overrun,
  output logic [ERR_CNT_W-1:0] frame_err_cnt,
  output logic                 irq
);

  rx_state_e             state_q, state_d;
  logic [BYTE_W-1:0]     hold_q, hold_d;
  logic                  fin_q, fin_d;
  logic                  ovr_q, ovr_d;
  logic [ERR_CNT_W-1:0]  ferr_q, ferr_d;
  logic                  irq_q, irq_d;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  ovr_evt;

  assign pop = rd_ready && !empty;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (hold_q),
    .pop_i   (pop),
    .rdata_o (rd_data),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Capture / write / acknowledge sequencing.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    fin_d   = 1'b0;
    push    = 1'b0;
    ovr_evt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_irq) begin
          hold_d  = rx_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (rx_en) begin
          push    = !full || pop;
          ovr_evt = full && !pop;
        end
        fin_d   = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky status; a same-cycle event beats the clear.
  always_comb begin
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (ovr_evt)         ovr_d = 1'b1;
    else if (clr_status) ovr_d = 1'b0;
    if (clr_status)
      ferr_d = rx_frame_err ? ERR_CNT_W'(1) : '0;
    else if (rx_frame_err && !(&ferr_q))
      ferr_d = ferr_q + 1'b1;
  end

  // Level interrupt from current occupancy and status.
  always_comb begin
    irq_d = irq_en &&
            ((irq_thresh != '0 && fifo_count >= irq_thresh) ||
             ovr_q || ferr_q != '0);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      fin_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      fin_q   <= fin_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      irq_q   <= irq_d;
    end
  end

  assign rx_finish      = fin_q;
  assign rd_valid       = !empty;
  assign status_overrun = ovr_q;
  assign frame_err_cnt  = ferr_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl.
// Expected bytes queued on send, compared on pop.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_en = 1'b1;
  logic          rx_irq = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_frame_err = 1'b0;
  logic          rx_finish;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_ready = 1'b0;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] irq_thresh = '0;
  logic          irq_en = 1'b0;
  logic          clr_status = 1'b0;
  logic          status_overrun;
  logic [7:0]    frame_err_cnt;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb [$];
  int mcount = 0;
  bit mov = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_en          (rx_en),
    .rx_irq         (rx_irq),
    .rx_data        (rx_data),
    .rx_frame_err   (rx_frame_err),
    .rx_finish      (rx_finish),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_ready       (rd_ready),
    .fifo_count     (fifo_count),
    .irq_thresh     (irq_thresh),
    .irq_en         (irq_en),
    .clr_status     (clr_status),
    .status_overrun (status_overrun),
    .frame_err_cnt  (frame_err_cnt),
    .irq            (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is #1 after a posedge; returns in the IDLE cycle after ACK.
  task automatic send(input logic [7:0] b, input bit popw);
    bit room;
    bit popped;
    popped = 0;
    rx_irq  = 1'b1;
    rx_data = b;
    tick();
    rx_irq  = 1'b0;
    rx_data = '0;
    chk("no_early_finish", {31'd0, rx_finish}, 32'd0);
    room = (mcount < DEPTH);
    if (popw && mcount > 0) begin
      chk("pop_in_write", {24'd0, rd_data}, {24'd0, sb.pop_front()});
      rd_ready = 1'b1;
      mcount--;
      popped = 1;
    end
    if (rx_en) begin
      if (room || popped) begin
        sb.push_back(b);
        mcount++;
      end else begin
        mov = 1;
      end
    end
    tick();
    rd_ready = 1'b0;
    chk("finish", {31'd0, rx_finish}, 32'd1);
    chk("count", {{(32-CW){1'b0}}, fifo_count}, mcount);
    chk("valid", {31'd0, rd_valid}, {31'd0, mcount != 0});
    tick();
    chk("finish_one", {31'd0, rx_finish}, 32'd0);
  endtask

  task automatic pop_one();
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      chk("rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("rd_data", {24'd0, rd_data}, {24'd0, sb.pop_front()});
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      mcount--;
      chk("count_pop", {{(32-CW){1'b0}}, fifo_count}, mcount);
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) pop_one();
    chk("drained_valid", {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    bit saw_fin;
    #12;
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_data", {24'd0, rd_data}, 32'd0);
    chk("rst_count", {{(32-CW){1'b0}}, fifo_count}, 32'd0);
    chk("rst_finish", {31'd0, rx_finish}, 32'd0);
    chk("rst_ovr", {31'd0, status_overrun}, 32'd0);
    chk("rst_ferr", {24'd0, frame_err_cnt}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    tick();

    // single byte
    send(8'hA5, 0);
    pop_one();
    chk("single_empty", {31'd0, rd_valid}, 32'd0);

    // ordering and pointer wrap
    for (int i = 0; i < 20; i++) begin
      send(8'(i), 0);
      if (i % 3 == 2) begin
        pop_one();
        pop_one();
      end
    end
    drain();

    // overrun: 17 bytes into 16 slots
    for (int i = 0; i < 17; i++) send(8'(8'h80 + i), 0);
    chk("ovr_count", {{(32-CW){1'b0}}, fifo_count}, DEPTH);
    chk("ovr_flag", {31'd0, status_overrun}, {31'd0, mov});
    chk("ovr_head", {24'd0, rd_data}, {24'd0, sb[0]});

    // full with simultaneous pop
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    mov = 0;
    chk("ovr_clr", {31'd0, status_overrun}, 32'd0);
    send(8'h55, 1);
    chk("fullpop_count", {{(32-CW){1'b0}}, fifo_count}, DEPTH);
    chk("fullpop_ovr", {31'd0, status_overrun}, {31'd0, mov});
    drain();

    // threshold interrupt
    irq_en = 1'b1;
    irq_thresh = CW'(4);
    for (int i = 0; i < 3; i++) send(8'(8'h10 + i), 0);
    tick();
    chk("irq_below", {31'd0, irq}, 32'd0);
    send(8'h13, 0);
    tick();
    chk("irq_at", {31'd0, irq}, 32'd1);
    drain();
    tick();
    tick();
    chk("irq_drained", {31'd0, irq}, 32'd0);

    // frame error saturation
    rx_frame_err = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    rx_frame_err = 1'b0;
    chk("ferr_sat", {24'd0, frame_err_cnt}, 32'd255);
    tick();
    chk("irq_ferr", {31'd0, irq}, 32'd1);
    clr_status = 1'b1;
    rx_frame_err = 1'b1;
    tick();
    clr_status = 1'b0;
    rx_frame_err = 1'b0;
    chk("ferr_clr_evt", {24'd0, frame_err_cnt}, 32'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("ferr_clr", {24'd0, frame_err_cnt}, 32'd0);
    tick();
    chk("irq_clr", {31'd0, irq}, 32'd0);
    irq_en = 1'b0;

    // disabled receive
    rx_en = 1'b0;
    send(8'h3C, 0);
    chk("dis_count", {{(32-CW){1'b0}}, fifo_count}, 32'd0);
    chk("dis_ovr", {31'd0, status_overrun}, 32'd0);
    rx_en = 1'b1;

    // reset in WRITE
    send(8'h77, 0);
    rx_irq  = 1'b1;
    rx_data = 8'hE1;
    tick();
    rx_irq  = 1'b0;
    rst_n   = 1'b0;
    #1;
    sb.delete();
    mcount = 0;
    chk("mid_rst_count", {{(32-CW){1'b0}}, fifo_count}, 32'd0);
    chk("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, rd_data}, 32'd0);
    chk("mid_rst_finish", {31'd0, rx_finish}, 32'd0);
    tick();
    rst_n = 1'b1;
    saw_fin = 0;
    repeat (5) begin
      tick();
      if (rx_finish) saw_fin = 1;
    end
    chk("no_fin_after_rst", {31'd0, saw_fin}, 32'd0);
    chk("post_rst_count", {{(32-CW){1'b0}}, fifo_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
